// File: rtl/data_mem_pkg.sv
// Shared constants and queue-entry type for the data-memory responder.
package data_mem_pkg;

    localparam int LAT_MIN    = 1;
    localparam int LAT_MAX    = 7;
    localparam int QDEPTH_MAX = 4;
    localparam int TIMER_W    = 3;

    typedef struct packed {
        logic               wr;
        logic [3:0]         wstrb;
        logic [31:0]        addr;
        logic [31:0]        wdata;
        logic [TIMER_W-1:0] timer;
    } queueEntry_t;

endpackage

// File: rtl/sram_bytemem.sv
// Word RAM with per-byte write enables and a combinational read port; no reset.
module sram_bytemem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            wstrb,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << DEPTH_LOG2) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_sram_slave.sv
// Data-memory responder: sram-like req/addr_ok + data_ok handshake over an internal
// byte-enabled RAM, with a fixed service latency and an in-order outstanding queue.
module data_sram_slave
    import data_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2,
    parameter int QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [TIMER_W-1:0] LOAD_TIMER = TIMER_W'(LATENCY - 1);
    localparam logic [TIMER_W-1:0] PUSH_TIMER = (LATENCY > 1) ? TIMER_W'(LATENCY - 2) : '0;
    localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(QDEPTH);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : gBadLatency
        $error("data_sram_slave: LATENCY out of range");
    end
    if (QDEPTH < 1 || QDEPTH > QDEPTH_MAX) begin : gBadQdepth
        $error("data_sram_slave: QDEPTH out of range");
    end

    queueEntry_t      queue [QDEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

    queueEntry_t incoming;
    queueEntry_t pushEntry;
    queueEntry_t cand;
    logic        accept;
    logic        candValid;
    logic        complete;
    logic        push;
    logic        pop;
    logic        inRange;
    logic        memWe;
    logic [31:0] memRdata;
    logic        unusedAddrBits;

    // Handshake: a request transfers on any rising edge where req & addr_ok are both
    // high; the requester holds req and payload stable until then. data_ok is a
    // one-cycle pulse per request, strictly in acceptance order.
    always_comb begin
        incoming       = '0;
        incoming.wr    = wr;
        incoming.wstrb = wstrb;
        incoming.addr  = addr;
        incoming.wdata = wdata;
        incoming.timer = LOAD_TIMER;

        pushEntry       = incoming;
        pushEntry.timer = PUSH_TIMER;

        accept = req & addr_ok;

        // The timer counts the accept cycle itself, so at LATENCY=1 an incoming
        // request into an empty queue completes on its own accept edge.
        cand      = (count != '0) ? queue[head] : incoming;
        candValid = (count != '0) | accept;
        complete  = candValid & (cand.timer == '0);
        pop       = complete & (count != '0);
        push      = accept & ~(complete & (count == '0));

        inRange   = (cand.addr >> (DEPTH_LOG2 + 2)) == 32'd0;
        memWe     = complete & cand.wr & inRange;
        countNext = count + CNT_W'(push) - CNT_W'(pop);
    end

    assign unusedAddrBits = ^cand.addr[1:0];

    sram_bytemem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) uMem (
        .clk   (clk),
        .we    (memWe),
        .wstrb (cand.wstrb),
        .addr  (cand.addr[DEPTH_LOG2+1:2]),
        .wdata (cand.wdata),
        .rdata (memRdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QDEPTH; i++) queue[i] <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            addr_ok <= 1'b0;
            data_ok <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (queue[i].timer != '0) queue[i].timer <= queue[i].timer - 1'b1;
            end
            if (push) begin
                queue[tail] <= pushEntry;
                tail        <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
            end
            if (pop) head <= (head == LAST_PTR) ? '0 : head + 1'b1;
            count   <= countNext;
            addr_ok <= countNext < FULL_COUNT;
            data_ok <= complete;
            if (complete) begin
                err <= ~inRange;
                if (!cand.wr) rdata <= inRange ? memRdata : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed bench for data_sram_slave: three instances cover LATENCY 2, 3 and 1.
module tb_data_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        reqA, reqB, reqC;
    logic        addrOkA, addrOkB, addrOkC;
    logic        dataOkA, dataOkB, dataOkC;
    logic [31:0] rdataA, rdataB, rdataC;
    logic        errA, errB, errC;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_slave #(.DEPTH_LOG2(10), .LATENCY(2), .QDEPTH(2)) dutA (
        .clk(clk), .rst(rst), .req(reqA), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addrOkA), .data_ok(dataOkA), .rdata(rdataA), .err(errA));
    data_sram_slave #(.DEPTH_LOG2(10), .LATENCY(3), .QDEPTH(2)) dutB (
        .clk(clk), .rst(rst), .req(reqB), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addrOkB), .data_ok(dataOkB), .rdata(rdataB), .err(errB));
    data_sram_slave #(.DEPTH_LOG2(10), .LATENCY(1), .QDEPTH(2)) dutC (
        .clk(clk), .rst(rst), .req(reqC), .wr(wr), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addrOkC), .data_ok(dataOkC), .rdata(rdataC), .err(errC));

    typedef struct {
        logic        w;
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] expRd;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic        w;
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] expRd;
    } stream_t;

    vec_t    vecs[18];
    stream_t sItems[4];
    int      expAcc[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic setReq(input int sel, input logic v);
        case (sel)
            0:       reqA = v;
            1:       reqB = v;
            default: reqC = v;
        endcase
    endtask

    function automatic logic getAddrOk(input int sel);
        case (sel)
            0:       return addrOkA;
            1:       return addrOkB;
            default: return addrOkC;
        endcase
    endfunction

    function automatic logic getDataOk(input int sel);
        case (sel)
            0:       return dataOkA;
            1:       return dataOkB;
            default: return dataOkC;
        endcase
    endfunction

    function automatic logic [31:0] getRdata(input int sel);
        case (sel)
            0:       return rdataA;
            1:       return rdataB;
            default: return rdataC;
        endcase
    endfunction

    function automatic logic getErr(input int sel);
        case (sel)
            0:       return errA;
            1:       return errB;
            default: return errC;
        endcase
    endfunction

    task automatic drive(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        wr = w; wstrb = s; addr = a; wdata = d;
    endtask

    // One request: wait for acceptance, then for data_ok; lat = cycles from accept.
    task automatic txn(input int sel, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic e, output int lat);
        int acc;
        int guard;
        @(negedge clk);
        drive(w, s, a, d);
        setReq(sel, 1'b1);
        guard = 0;
        while (!getAddrOk(sel) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        acc = cyc;
        @(negedge clk);
        setReq(sel, 1'b0);
        guard = 0;
        while (!getDataOk(sel) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        lat = getDataOk(sel) ? cyc - acc : -1;
        rd  = getRdata(sel);
        e   = getErr(sel);
    endtask

    // Streams sItems with req held high; every data_ok must land at accept+latency.
    task automatic runStream(input int sel, input int latency, input logic expFull, input string tag);
        int          expCycQ[$];
        logic [32:0] exp_q[$];
        int          accCyc[4];
        int          k;
        int          done;
        int          ec;
        logic [32:0] ed;
        logic        sawFull;
        logic        accepted;
        k = 0; done = 0; sawFull = 1'b0;
        @(negedge clk);
        drive(sItems[0].w, sItems[0].s, sItems[0].a, sItems[0].d);
        setReq(sel, 1'b1);
        for (int g = 0; g < 40 && done < 4; g++) begin
            if (getDataOk(sel)) begin
                if (expCycQ.size() == 0) begin
                    check({tag, "_spurious_dok"}, 32'd1, 32'd0);
                end else begin
                    ec = expCycQ.pop_front();
                    ed = exp_q.pop_front();
                    check({tag, "_dok_cycle"}, 32'(cyc), 32'(ec));
                    check({tag, "_err"}, {31'd0, getErr(sel)}, 32'd0);
                    if (ed[32]) check({tag, "_rdata"}, getRdata(sel), ed[31:0]);
                end
                done++;
            end
            accepted = (k < 4) && getAddrOk(sel);
            if (k < 4 && !accepted) sawFull = 1'b1;
            if (accepted) begin
                accCyc[k] = cyc;
                expCycQ.push_back(cyc + latency);
                exp_q.push_back({~sItems[k].w, sItems[k].expRd});
            end
            @(negedge clk);
            if (accepted) begin
                k++;
                if (k < 4) drive(sItems[k].w, sItems[k].s, sItems[k].a, sItems[k].d);
                else setReq(sel, 1'b0);
            end
        end
        check({tag, "_completions"}, 32'(done), 32'd4);
        check({tag, "_accepts"}, 32'(k), 32'd4);
        check({tag, "_addr_ok_dropped"}, {31'd0, sawFull}, {31'd0, expFull});
        for (int i = 1; i < 4; i++) begin
            if (i < k) check($sformatf("%s_accept_offset%0d", tag, i), 32'(accCyc[i] - accCyc[0]), 32'(expAcc[i]));
        end
    endtask

    // Protocol monitors: completion only with something queued or accepted, count bounded.
    logic idleA = 1'b1, idleB = 1'b1, idleC = 1'b1;

    task automatic monitor(input string name, input logic dok, input logic idle, input int cnt);
        checks++;
        if (dok && idle) begin
            errors++;
            $display("FAIL %s_dok_while_empty actual=1 required=0", name);
        end
        checks++;
        if (cnt > 2) begin
            errors++;
            $display("FAIL %s_count_bound actual=%0d required<=2", name, cnt);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            idleA = 1'b1; idleB = 1'b1; idleC = 1'b1;
        end else begin
            monitor("monA", dataOkA, idleA, int'(dutA.count));
            monitor("monB", dataOkB, idleB, int'(dutB.count));
            monitor("monC", dataOkC, idleC, int'(dutC.count));
            idleA = (dutA.count == 0) && !(reqA && addrOkA);
            idleB = (dutB.count == 0) && !(reqB && addrOkB);
            idleC = (dutC.count == 0) && !(reqC && addrOkC);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        logic        sawDok;

        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 4'h2, 32'h0000_0020, 32'h0000_AA00, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'h1122_AA44, 1'b0};
        vecs[5]  = '{1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 32'h1122_AA44, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b1, 4'hF, 32'h0000_1000, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{1'b1, 4'hF, 32'h0000_0030, 32'hA5A5_A5A5, 32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b1, 4'h0, 32'h0000_0030, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[11] = '{1'b0, 4'h0, 32'h0000_0030, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[12] = '{1'b1, 4'h8, 32'h0000_0010, 32'hEE00_0000, 32'hA5A5_A5A5, 1'b0};
        vecs[13] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hEEAD_BEEF, 1'b0};
        vecs[14] = '{1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};
        vecs[15] = '{1'b0, 4'h0, 32'h0000_0013, 32'h0,         32'hEEAD_BEEF, 1'b0};
        vecs[16] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h0102_0304, 32'hEEAD_BEEF, 1'b0};
        vecs[17] = '{1'b0, 4'h0, 32'h0000_0FFC, 32'h0,         32'h0102_0304, 1'b0};

        rst = 1'b0;
        reqA = 1'b0; reqB = 1'b0; reqC = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_addr_ok", {31'd0, addrOkA}, 32'd0);
        check("reset_data_ok", {31'd0, dataOkA}, 32'd0);
        check("reset_rdata", rdataA, 32'd0);
        check("reset_err", {31'd0, errA}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("first_cycle_addr_ok", {31'd0, addrOkA}, 32'd1);

        // Single transactions at LATENCY=2
        for (int i = 0; i < 18; i++) begin
            txn(0, vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d, rd, e, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].expErr});
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
        end

        // Back-to-back at LATENCY=3, QDEPTH=2: queue fills, addr_ok holds off
        sItems[0] = '{1'b1, 4'hF, 32'h0000_0040, 32'h0BAD_F00D, 32'h0};
        sItems[1] = '{1'b0, 4'h0, 32'h0000_0040, 32'h0,         32'h0BAD_F00D};
        sItems[2] = '{1'b1, 4'hF, 32'h0000_0044, 32'h600D_CAFE, 32'h0};
        sItems[3] = '{1'b0, 4'h0, 32'h0000_0044, 32'h0,         32'h600D_CAFE};
        expAcc = '{0, 1, 3, 4};
        runStream(1, 3, 1'b1, "b2b_lat3");

        // LATENCY=1 alternating store/load every cycle
        sItems[0] = '{1'b1, 4'hF, 32'h0000_0050, 32'h1111_1111, 32'h0};
        sItems[1] = '{1'b0, 4'h0, 32'h0000_0050, 32'h0,         32'h1111_1111};
        sItems[2] = '{1'b1, 4'hF, 32'h0000_0050, 32'h2222_2222, 32'h0};
        sItems[3] = '{1'b0, 4'h0, 32'h0000_0050, 32'h0,         32'h2222_2222};
        expAcc = '{0, 1, 2, 3};
        runStream(2, 1, 1'b0, "sweep_lat1");

        // Reset with two requests outstanding, one a store to 0x30
        txn(1, 1'b1, 4'hF, 32'h0000_0030, 32'hA5A5_A5A5, rd, e, lat);
        check("rst_prep_latency", 32'(lat), 32'd3);
        @(negedge clk);
        drive(1'b1, 4'hF, 32'h0000_0030, 32'h0000_0055);
        reqB = 1'b1;
        check("rst_store_accept", {31'd0, addrOkB}, 32'd1);
        @(negedge clk);
        drive(1'b0, 4'h0, 32'h0000_0030, 32'h0);
        check("rst_load_accept", {31'd0, addrOkB}, 32'd1);
        @(negedge clk);
        reqB = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_addr_ok", {31'd0, addrOkB}, 32'd0);
        check("midrst_data_ok", {31'd0, dataOkB}, 32'd0);
        check("midrst_rdata", rdataB, 32'd0);
        check("midrst_err", {31'd0, errB}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_hold_addr_ok", {31'd0, addrOkB}, 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("after_rst_addr_ok", {31'd0, addrOkB}, 32'd1);
        sawDok = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dataOkB) sawDok = 1'b1;
        end
        check("dropped_no_data_ok", {31'd0, sawDok}, 32'd0);
        txn(1, 1'b0, 4'h0, 32'h0000_0030, 32'h0, rd, e, lat);
        check("dropped_store_rdata", rd, 32'hA5A5_A5A5);
        check("dropped_store_err", {31'd0, e}, 32'd0);
        check("dropped_store_latency", 32'(lat), 32'd3);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
